// File: rtl/pcie_tx_cmd_fifo_v2_if.sv
// rtl/pcie_tx_cmd_fifo_v2_if.sv - write/read/status bundle of the TX command FIFO
// PCIE_TX_CMD_FIFO_PARITY_EN adds the par_err status line.
interface pcie_tx_cmd_fifo_v2_if #(
    parameter int P_DATA_WIDTH  = 46,
    parameter int P_DEPTH_WIDTH = 5
);
    logic                     wr_en;
    logic [P_DATA_WIDTH-1:0]  wr_data;
    logic                     full_n;
    logic                     almost_full_n;
    logic                     rd_en;
    logic [P_DATA_WIDTH-1:0]  rd_data;
    logic                     empty_n;
    logic [P_DEPTH_WIDTH:0]   level;
    logic                     err_clr;
    logic                     ovf_err;
    logic                     udf_err;
`ifdef PCIE_TX_CMD_FIFO_PARITY_EN
    logic                     par_err;

    modport slave (
        input  wr_en, wr_data, rd_en, err_clr,
        output full_n, almost_full_n, rd_data, empty_n, level, ovf_err, udf_err, par_err
    );
    modport master (
        output wr_en, wr_data, rd_en, err_clr,
        input  full_n, almost_full_n, rd_data, empty_n, level, ovf_err, udf_err, par_err
    );
`else
    modport slave (
        input  wr_en, wr_data, rd_en, err_clr,
        output full_n, almost_full_n, rd_data, empty_n, level, ovf_err, udf_err
    );
    modport master (
        output wr_en, wr_data, rd_en, err_clr,
        input  full_n, almost_full_n, rd_data, empty_n, level, ovf_err, udf_err
    );
`endif
endinterface

// File: rtl/pcie_tx_cmd_fifo_v2.sv
// rtl/pcie_tx_cmd_fifo_v2.sv - show-ahead TX command FIFO with unit-granular full/empty
// Optional per-word parity checking is enabled by PCIE_TX_CMD_FIFO_PARITY_EN.
module pcie_tx_cmd_fifo_v2 #(
    parameter int P_DATA_WIDTH   = 46,
    parameter int P_DEPTH_WIDTH  = 5,
    parameter int P_ALLOC_WIDTH  = 1,
    parameter int P_AFULL_THRESH = 24
) (
    input  logic                   clk,
    input  logic                   rst_n,
    pcie_tx_cmd_fifo_v2_if.slave   fifo_if
);
    localparam int DW    = P_DEPTH_WIDTH;
    localparam int AW    = P_ALLOC_WIDTH;
    localparam int DEPTH = 1 << DW;
`ifdef PCIE_TX_CMD_FIFO_PARITY_EN
    localparam int RW    = P_DATA_WIDTH + 1;
`else
    localparam int RW    = P_DATA_WIDTH;
`endif
    localparam logic [DW:0] PTR_ONE  = (DW+1)'(1);
    localparam logic [DW:0] AFULL_TH = (DW+1)'(P_AFULL_THRESH);

    logic [DW:0]   front_q, front_d;
    logic [DW:0]   front_p1_q, front_p1_d;
    logic [DW:0]   rear_q, rear_d;
    logic [DW:0]   rear_dly_q, rear_dly_d;
    logic          ovf_err_q, ovf_err_d;
    logic          udf_err_q, udf_err_d;

    logic [RW-1:0] mem_q [DEPTH];
    logic [RW-1:0] rd_word_q;
    logic [RW-1:0] wr_word;
    logic [DW-1:0] rd_addr;

    logic          full_n;
    logic          empty_n;
    logic          wr_acc;
    logic          rd_acc;
    logic [DW:0]   level;

    // Full uses the live rear pointer; empty uses the delayed one so a word is
    // only presented once the registered RAM read has picked it up.
    always_comb begin
        full_n  = ~((rear_q[DW] ^ front_q[DW]) & (rear_q[DW-1:AW] == front_q[DW-1:AW]));
        empty_n = (front_q[DW:AW] != rear_dly_q[DW:AW]);
        wr_acc  = fifo_if.wr_en & full_n;
        rd_acc  = fifo_if.rd_en & empty_n;
        level   = rear_q - front_q;

        rear_d     = wr_acc ? rear_q + PTR_ONE : rear_q;
        rear_dly_d = rear_q;
        front_d    = rd_acc ? front_p1_q : front_q;
        front_p1_d = rd_acc ? front_p1_q + PTR_ONE : front_p1_q;
        rd_addr    = rd_acc ? front_p1_q[DW-1:0] : front_q[DW-1:0];

        ovf_err_d = ovf_err_q | (fifo_if.wr_en & ~full_n);
        udf_err_d = udf_err_q | (fifo_if.rd_en & ~empty_n);
        if (fifo_if.err_clr) begin
            ovf_err_d = 1'b0;
            udf_err_d = 1'b0;
        end
    end

`ifdef PCIE_TX_CMD_FIFO_PARITY_EN
    logic par_err_q, par_err_d;

    always_comb begin
        wr_word   = {^fifo_if.wr_data, fifo_if.wr_data};
        par_err_d = par_err_q
                  | (rd_acc & ((^rd_word_q[P_DATA_WIDTH-1:0]) != rd_word_q[RW-1]));
        if (fifo_if.err_clr) begin
            par_err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= par_err_d;
        end
    end

    assign fifo_if.par_err = par_err_q;
`else
    always_comb begin
        wr_word = fifo_if.wr_data;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            front_q    <= '0;
            front_p1_q <= PTR_ONE;
            rear_q     <= '0;
            rear_dly_q <= '0;
            ovf_err_q  <= 1'b0;
            udf_err_q  <= 1'b0;
        end else begin
            front_q    <= front_d;
            front_p1_q <= front_p1_d;
            rear_q     <= rear_d;
            rear_dly_q <= rear_dly_d;
            ovf_err_q  <= ovf_err_d;
            udf_err_q  <= udf_err_d;
        end
    end

    // Plain synchronous RAM with registered read; no reset so it maps to block RAM.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[rear_q[DW-1:0]] <= wr_word;
        end
        rd_word_q <= mem_q[rd_addr];
    end

    assign fifo_if.full_n        = full_n;
    assign fifo_if.almost_full_n = (level < AFULL_TH);
    assign fifo_if.empty_n       = empty_n;
    assign fifo_if.level         = level;
    assign fifo_if.rd_data       = rd_word_q[P_DATA_WIDTH-1:0];
    assign fifo_if.ovf_err       = ovf_err_q;
    assign fifo_if.udf_err       = udf_err_q;
endmodule

// File: tb/tb_pcie_tx_cmd_fifo_v2.sv
// tb/tb_pcie_tx_cmd_fifo_v2.sv - directed self-checking bench for pcie_tx_cmd_fifo_v2
module tb_pcie_tx_cmd_fifo_v2;
    localparam int DWID = 46;
    localparam int PDW  = 5;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    pcie_tx_cmd_fifo_v2_if #(.P_DATA_WIDTH(DWID), .P_DEPTH_WIDTH(PDW)) bus ();

    pcie_tx_cmd_fifo_v2 #(
        .P_DATA_WIDTH(DWID), .P_DEPTH_WIDTH(PDW), .P_ALLOC_WIDTH(1), .P_AFULL_THRESH(24)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .fifo_if (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    logic [DWID-1:0] q[$];
    logic [DWID-1:0] nxt;

    initial begin
        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.wr_en = 1'b0;
        bus.wr_data = '0;
        bus.rd_en = 1'b0;
        bus.err_clr = 1'b0;
        tick();
        tick();
        chk("rst_full_n", bus.full_n, 1);
        chk("rst_afull_n", bus.almost_full_n, 1);
        chk("rst_empty_n", bus.empty_n, 0);
        chk("rst_level", bus.level, 0);
        chk("rst_ovf", bus.ovf_err, 0);
        chk("rst_udf", bus.udf_err, 0);
        rst_n = 1'b1;
        tick();

        // one two-word unit: invisible until complete and committed
        bus.wr_en = 1'b1; bus.wr_data = 46'h1;
        tick();
        chk("w1_empty_n", bus.empty_n, 0);
        chk("w1_level", bus.level, 1);
        bus.wr_data = 46'h2;
        tick();
        chk("w2_empty_n", bus.empty_n, 0);
        bus.wr_en = 1'b0;
        tick();
        chk("w2_empty_n_late", bus.empty_n, 1);
        chk("w2_rd_data", bus.rd_data, 46'h1);
        chk("w2_level", bus.level, 2);
        bus.rd_en = 1'b1;
        tick();
        chk("pop1_rd_data", bus.rd_data, 46'h2);
        chk("pop1_level", bus.level, 1);
        tick();
        bus.rd_en = 1'b0;
        chk("pop2_empty_n", bus.empty_n, 0);
        chk("pop2_level", bus.level, 0);

        // fill to 32
        for (int k = 0; k < 32; k++) begin
            bus.wr_en = 1'b1; bus.wr_data = 46'(100 + k);
            tick();
            chk("fill_level", bus.level, 64'(k + 1));
            chk("fill_afull_n", bus.almost_full_n, 64'((k + 1) < 24));
            chk("fill_full_n", bus.full_n, 64'((k + 1) < 32));
        end
        bus.wr_data = 46'hBAD;
        tick();
        bus.wr_en = 1'b0;
        chk("ovf_err", bus.ovf_err, 1);
        chk("ovf_level", bus.level, 32);
        chk("ovf_udf_clean", bus.udf_err, 0);
        tick();

        // drain back-to-back
        bus.rd_en = 1'b1;
        for (int k = 0; k < 32; k++) begin
            chk("drain_empty_n", bus.empty_n, 1);
            chk("drain_rd_data", bus.rd_data, 64'(100 + k));
            tick();
        end
        chk("drain_empty_n_end", bus.empty_n, 0);
        chk("drain_level_end", bus.level, 0);
        chk("drain_udf_pre", bus.udf_err, 0);
        tick();
        bus.rd_en = 1'b0;
        chk("udf_err", bus.udf_err, 1);
        chk("udf_level", bus.level, 0);
        bus.err_clr = 1'b1;
        tick();
        chk("clr_ovf", bus.ovf_err, 0);
        chk("clr_udf", bus.udf_err, 0);
        bus.rd_en = 1'b1;
        tick();
        bus.rd_en = 1'b0;
        bus.err_clr = 1'b0;
        chk("clr_priority_udf", bus.udf_err, 0);

        // steady-state streaming across pointer wrap
        nxt = 46'd500;
        for (int k = 0; k < 4; k++) begin
            bus.wr_en = 1'b1; bus.wr_data = nxt;
            q.push_back(nxt);
            nxt = nxt + 46'd1;
            tick();
        end
        bus.wr_en = 1'b0;
        tick();
        for (int k = 0; k < 100; k++) begin
            bus.wr_en = 1'b1; bus.wr_data = nxt;
            bus.rd_en = 1'b1;
            chk("stream_rd_data", bus.rd_data, q[0]);
            tick();
            q.push_back(nxt);
            void'(q.pop_front());
            nxt = nxt + 46'd1;
            chk("stream_level", bus.level, 4);
        end
        bus.rd_en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            bus.wr_data = 46'(900 + k);
            tick();
        end
        chk("pre_rst_level", bus.level, 10);

        // asynchronous reset mid-burst
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_level", bus.level, 0);
        chk("arst_empty_n", bus.empty_n, 0);
        chk("arst_full_n", bus.full_n, 1);
        bus.wr_en = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        bus.wr_en = 1'b1; bus.wr_data = 46'h3A;
        tick();
        bus.wr_data = 46'h3B;
        tick();
        bus.wr_en = 1'b0;
        tick();
        chk("rt_empty_n", bus.empty_n, 1);
        chk("rt_rd_data0", bus.rd_data, 46'h3A);
        bus.rd_en = 1'b1;
        tick();
        chk("rt_rd_data1", bus.rd_data, 46'h3B);
        tick();
        bus.rd_en = 1'b0;
        chk("rt_empty_end", bus.empty_n, 0);
        chk("rt_level_end", bus.level, 0);

`ifdef PCIE_TX_CMD_FIFO_PARITY_EN
        // words land at RAM entries 2 and 3; corrupt entry 3
        bus.wr_en = 1'b1; bus.wr_data = 46'h55;
        tick();
        bus.wr_data = 46'h66;
        tick();
        bus.wr_en = 1'b0;
        tick();
        #2;
        dut.mem_q[3][0] = ~dut.mem_q[3][0];
        tick();
        chk("par_pre", bus.par_err, 0);
        bus.rd_en = 1'b1;
        tick();
        chk("par_good_pop", bus.par_err, 0);
        tick();
        bus.rd_en = 1'b0;
        chk("par_bad_pop", bus.par_err, 1);
        bus.err_clr = 1'b1;
        tick();
        bus.err_clr = 1'b0;
        chk("par_clr", bus.par_err, 0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
